// File: rtl/mem_stage_hs_if.sv
// Data-memory bus between the MEM stage (master) and a variable-latency memory (slave).
// Request side is held until gnt; read data returns later with rvalid.
interface mem_stage_hs_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   localparam int NB = DATA_WIDTH / 8;

   logic                  dmem_req;
   logic                  dmem_we;
   logic [ADDR_WIDTH-1:0] dmem_addr;
   logic [NB-1:0]         dmem_be;
   logic [DATA_WIDTH-1:0] dmem_wdata;
   logic                  dmem_gnt;
   logic                  dmem_rvalid;
   logic [DATA_WIDTH-1:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_gnt, dmem_rvalid, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_gnt, dmem_rvalid, dmem_rdata
   );
endinterface

// File: rtl/mem_stage_hs.sv
// Pipeline MEM stage driving a req/gnt/rvalid data memory: byte enables, lane-replicated
// store data, load alignment/extension, misalignment suppression and upstream stall.
module mem_stage_hs #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [1:0]            type_control,
   input  logic                  sign_ext_flag,
   input  logic [ADDR_WIDTH-1:0] alu_result,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic                  stall,
   output logic                  out_valid,
   output logic [ADDR_WIDTH-1:0] alu_result_out,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  misaligned,
   mem_stage_hs_if.master        dmem
);
   localparam int NB  = DATA_WIDTH / 8;
   localparam int OFF = $clog2(NB);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t                state_reg;
   logic                  out_valid_reg;
   logic                  misaligned_reg;
   logic [ADDR_WIDTH-1:0] alu_result_out_reg;
   logic [DATA_WIDTH-1:0] read_data_reg;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [1:0]            type_reg;
   logic                  sext_reg;
   logic [OFF-1:0]        off_reg;
   logic                  we_reg;
   logic                  req_reg;
   logic [ADDR_WIDTH-1:0] dmem_addr_reg;
   logic [NB-1:0]         be_reg;
   logic [DATA_WIDTH-1:0] wdata_reg;

   logic                  mem_op;
   logic                  mis_next;
   logic [OFF-1:0]        off_next;
   logic [NB-1:0]         be_base;
   logic [NB-1:0]         be_next;
   logic [DATA_WIDTH-1:0] wdata_next;
   logic [DATA_WIDTH-1:0] load_next;

   // Shift the addressed bytes down, keep the access width, then sign/zero-fill above it.
   function automatic logic [DATA_WIDTH-1:0] extend_load(
      input logic [DATA_WIDTH-1:0] rdata,
      input logic [OFF-1:0]        off,
      input logic [1:0]            ty,
      input logic                  sext
   );
      logic [DATA_WIDTH-1:0] shifted;
      logic [DATA_WIDTH-1:0] mask;
      logic [6:0]            nbits;
      logic                  sign;
      shifted = rdata >> {off, 3'b000};
      nbits   = 7'd8 << ty;
      mask    = ~({DATA_WIDTH{1'b1}} << nbits);
      sign    = |(shifted & mask & ~(mask >> 1));
      return (sext && sign) ? ((shifted & mask) | ~mask) : (shifted & mask);
   endfunction

   assign mem_op   = mem_read | mem_write;
   assign off_next = alu_result[OFF-1:0];

   always_comb begin
      mis_next = 1'b0;
      case (type_control)
         2'b01:   mis_next = alu_result[0];
         2'b10:   mis_next = |alu_result[1:0];
         2'b11:   mis_next = (DATA_WIDTH == 32) || (|alu_result[2:0]);
         default: mis_next = 1'b0;
      endcase
   end

   always_comb begin
      be_base = '1;
      case (type_control)
         2'b00:   be_base = NB'(1);
         2'b01:   be_base = NB'(3);
         2'b10:   be_base = NB'(15);
         default: be_base = '1;
      endcase
   end

   assign be_next = be_base << off_next;

   // Each lane repeats the byte of the store operand that falls in its position within the access.
   for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign wdata_next[8*gi +: 8] =
         (type_control == 2'b00) ? write_data[7:0] :
         (type_control == 2'b01) ? write_data[8*(gi % 2) +: 8] :
         (type_control == 2'b10) ? write_data[8*(gi % 4) +: 8] :
                                   write_data[8*gi +: 8];
   end

   assign load_next = extend_load(dmem.dmem_rdata, off_reg, type_reg, sext_reg);

   // Stall falls in the completion cycle so upstream moves exactly once per access.
   always_comb begin
      stall = 1'b0;
      case (state_reg)
         IDLE:    stall = in_valid && mem_op && !mis_next;
         REQ:     stall = !(dmem.dmem_gnt && we_reg);
         WAIT:    stall = !dmem.dmem_rvalid;
         default: stall = 1'b0;
      endcase
      if (rst) stall = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg          <= IDLE;
         out_valid_reg      <= 1'b0;
         misaligned_reg     <= 1'b0;
         alu_result_out_reg <= '0;
         read_data_reg      <= '0;
         addr_reg           <= '0;
         type_reg           <= 2'b00;
         sext_reg           <= 1'b0;
         off_reg            <= '0;
         we_reg             <= 1'b0;
         req_reg            <= 1'b0;
         dmem_addr_reg      <= '0;
         be_reg             <= '0;
         wdata_reg          <= '0;
      end else begin
         out_valid_reg  <= 1'b0;
         misaligned_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  if (!mem_op || mis_next) begin
                     out_valid_reg      <= 1'b1;
                     misaligned_reg     <= mem_op;
                     alu_result_out_reg <= alu_result;
                     read_data_reg      <= '0;
                  end else begin
                     addr_reg      <= alu_result;
                     type_reg      <= type_control;
                     sext_reg      <= sign_ext_flag;
                     off_reg       <= off_next;
                     we_reg        <= mem_write;
                     req_reg       <= 1'b1;
                     dmem_addr_reg <= {alu_result[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                     be_reg        <= be_next;
                     wdata_reg     <= wdata_next;
                     state_reg     <= REQ;
                  end
               end
            end
            REQ: begin
               if (dmem.dmem_gnt) begin
                  req_reg <= 1'b0;
                  if (we_reg) begin
                     out_valid_reg      <= 1'b1;
                     alu_result_out_reg <= addr_reg;
                     read_data_reg      <= '0;
                     state_reg          <= IDLE;
                  end else begin
                     state_reg <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (dmem.dmem_rvalid) begin
                  out_valid_reg      <= 1'b1;
                  alu_result_out_reg <= addr_reg;
                  read_data_reg      <= load_next;
                  state_reg          <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign out_valid        = out_valid_reg;
   assign misaligned       = misaligned_reg;
   assign alu_result_out   = alu_result_out_reg;
   assign read_data        = read_data_reg;
   assign dmem.dmem_req    = req_reg;
   assign dmem.dmem_we     = we_reg;
   assign dmem.dmem_addr   = dmem_addr_reg;
   assign dmem.dmem_be     = be_reg;
   assign dmem.dmem_wdata  = wdata_reg;
endmodule

// File: tb/tb_mem_stage_hs.sv
// Bench for mem_stage_hs: a 32-bit and a 64-bit instance, one active at a time, driven by a
// reactive memory responder; table vectors, corner sequences and random ops against a model.
module tb_mem_stage_hs;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel64 = 1'b0;
   logic        in_valid = 1'b0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [1:0]  type_control = 2'b00;
   logic        sign_ext_flag = 1'b0;
   logic [31:0] alu_result = '0;
   logic [63:0] write_data = '0;
   logic        gnt = 1'b0;
   logic        rvalid = 1'b0;
   logic [63:0] rdata_in = '0;

   logic        stall32, ov32, mis32, stall64, ov64, mis64;
   logic [31:0] aro32, aro64, rd32;
   logic [63:0] rd64;

   int checks = 0;
   int errors = 0;
   int txn = 0;

   always #5 clk = ~clk;

   mem_stage_hs_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus32 ();
   mem_stage_hs_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus64 ();

   assign bus32.dmem_gnt    = gnt & ~sel64;
   assign bus32.dmem_rvalid = rvalid & ~sel64;
   assign bus32.dmem_rdata  = rdata_in[31:0];
   assign bus64.dmem_gnt    = gnt & sel64;
   assign bus64.dmem_rvalid = rvalid & sel64;
   assign bus64.dmem_rdata  = rdata_in;

   mem_stage_hs #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) u_dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid & ~sel64), .mem_read(mem_read),
      .mem_write(mem_write), .type_control(type_control), .sign_ext_flag(sign_ext_flag),
      .alu_result(alu_result), .write_data(write_data[31:0]), .stall(stall32),
      .out_valid(ov32), .alu_result_out(aro32), .read_data(rd32), .misaligned(mis32),
      .dmem(bus32.master)
   );

   mem_stage_hs #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) u_dut64 (
      .clk(clk), .rst(rst), .in_valid(in_valid & sel64), .mem_read(mem_read),
      .mem_write(mem_write), .type_control(type_control), .sign_ext_flag(sign_ext_flag),
      .alu_result(alu_result), .write_data(write_data), .stall(stall64),
      .out_valid(ov64), .alu_result_out(aro64), .read_data(rd64), .misaligned(mis64),
      .dmem(bus64.master)
   );

   logic        obs_stall, obs_ov, obs_mis, obs_req, obs_we;
   logic [31:0] obs_aro, obs_addr;
   logic [63:0] obs_rd, obs_wd;
   logic [7:0]  obs_be;
   assign obs_stall = sel64 ? stall64 : stall32;
   assign obs_ov    = sel64 ? ov64 : ov32;
   assign obs_mis   = sel64 ? mis64 : mis32;
   assign obs_aro   = sel64 ? aro64 : aro32;
   assign obs_rd    = sel64 ? rd64 : {32'h0, rd32};
   assign obs_req   = sel64 ? bus64.dmem_req : bus32.dmem_req;
   assign obs_we    = sel64 ? bus64.dmem_we : bus32.dmem_we;
   assign obs_addr  = sel64 ? bus64.dmem_addr : bus32.dmem_addr;
   assign obs_be    = sel64 ? bus64.dmem_be : {4'h0, bus32.dmem_be};
   assign obs_wd    = sel64 ? bus64.dmem_wdata : {32'h0, bus32.dmem_wdata};

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (txn %0d): got %h, expected %h", nm, txn, act, exp);
      end
   endtask

   // Reference model: byte-level arithmetic on sizes and offsets.
   function automatic bit m_mis(input bit s64, input logic [1:0] ty, input logic [31:0] a);
      int sz = 1 << ty;
      if (!s64 && ty == 2'd3) return 1'b1;
      return (a % sz) != 0;
   endfunction

   function automatic logic [7:0] m_be(input bit s64, input logic [1:0] ty, input logic [31:0] a);
      int nb = s64 ? 8 : 4;
      int sz = 1 << ty;
      int o  = int'(a % nb);
      int v  = ((1 << sz) - 1) << o;
      return v[7:0];
   endfunction

   function automatic logic [63:0] m_wd(input bit s64, input logic [1:0] ty, input logic [63:0] wd);
      logic [63:0] r = '0;
      int nb = s64 ? 8 : 4;
      int sz = 1 << ty;
      for (int i = 0; i < nb; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
      return r;
   endfunction

   function automatic logic [63:0] m_rd(input bit s64, input logic [1:0] ty, input bit sx,
                                        input logic [31:0] a, input logic [63:0] rdat);
      logic [63:0] v = '0;
      int nb = s64 ? 8 : 4;
      int sz = 1 << ty;
      int o  = int'(a % nb);
      for (int i = 0; i < sz; i++) v[8*i +: 8] = rdat[8*(o+i) +: 8];
      if (sx && v[8*sz-1])
         for (int i = sz; i < 8; i++) v[8*i +: 8] = 8'hFF;
      if (!s64) v[63:32] = '0;
      return v;
   endfunction

   // One instruction through the stage, with a memory that grants after gd request cycles
   // and returns read data rdl+1 cycles after the grant.
   task automatic do_op(input bit s64, input bit rd, input bit wr, input logic [1:0] ty,
                        input bit sx, input logic [31:0] addr, input logic [63:0] wd,
                        input logic [63:0] rdat, input int gd, input int rdl, input bit e_mis,
                        input logic [7:0] e_be, input logic [31:0] e_addr,
                        input logic [63:0] e_wd, input logic [63:0] e_rd);
      bit memop  = rd | wr;
      bit active = memop && !e_mis;
      int lat    = !active ? 1 : (wr ? 2 + gd : 3 + gd + rdl);
      int req_cnt = 0;
      int gnt_k   = -1;
      int done_k  = active ? -1 : 0;
      int ov_k    = -1;
      int nov     = 0;
      txn++;
      @(negedge clk);
      sel64 = s64; in_valid = 1'b1; mem_read = rd; mem_write = wr; type_control = ty;
      sign_ext_flag = sx; alu_result = addr; write_data = wd; gnt = 1'b0; rvalid = 1'b0;
      #1 chk("stall_accept", obs_stall, active);
      for (int k = 1; k <= lat + 1; k++) begin
         @(negedge clk);
         gnt = 1'b0; rvalid = 1'b0; rdata_in = {$urandom, $urandom};
         if (done_k < 0) begin
            in_valid = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
            type_control = 2'($urandom); sign_ext_flag = 1'($urandom);
            alu_result = $urandom; write_data = {$urandom, $urandom};
         end else begin
            in_valid = 1'b0;
         end
         if (obs_ov) begin
            nov++; ov_k = k;
            chk("read_data", obs_rd, active && !wr ? e_rd : 64'h0);
            chk("misaligned", obs_mis, memop && e_mis);
            chk("alu_result_out", obs_aro, addr);
         end
         if (obs_req) begin
            req_cnt++;
            chk("dmem_addr", obs_addr, e_addr);
            chk("dmem_be", obs_be, e_be);
            chk("dmem_we", obs_we, wr);
            if (wr) chk("dmem_wdata", obs_wd, e_wd);
            if (req_cnt == gd + 1) begin
               gnt = 1'b1; gnt_k = k;
               if (wr) done_k = k;
            end
         end
         if (!wr && gnt_k > 0 && k == gnt_k + 1 + rdl) begin
            rvalid = 1'b1; rdata_in = rdat; done_k = k;
         end
         #1 chk("stall", obs_stall, done_k < 0);
      end
      chk("out_valid_count", nov, 1);
      chk("latency", ov_k, lat);
      chk("req_cycles", req_cnt, active ? gd + 1 : 0);
      $display("txn %0d dw=%0d rd=%0d wr=%0d ty=%0d sx=%0d addr=%h gd=%0d rdl=%0d lat=%0d mis=%0d",
               txn, s64 ? 64 : 32, rd, wr, ty, sx, addr, gd, rdl, ov_k, e_mis);
   endtask

   typedef struct {
      bit          s64, rd, wr;
      logic [1:0]  ty;
      bit          sx;
      logic [31:0] addr;
      logic [63:0] wd, rdat;
      int          gd, rdl;
      bit          e_mis;
      logic [7:0]  e_be;
      logic [31:0] e_addr;
      logic [63:0] e_wd, e_rd;
   } vec_t;

   vec_t tbl [15];

   initial begin
      tbl[0]  = '{0,1,0,2'd0,1,32'h1003,64'h0,64'h80FF0000,0,0, 0,8'h08,32'h1000,64'h0,64'hFFFFFF80};
      tbl[1]  = '{0,0,1,2'd1,0,32'h2002,64'h1234ABCD,64'h0,3,0, 0,8'h0C,32'h2000,64'hABCDABCD,64'h0};
      tbl[2]  = '{0,1,0,2'd2,0,32'h0001,64'h0,64'h0,0,0, 1,8'h00,32'h0,64'h0,64'h0};
      tbl[3]  = '{0,0,0,2'd0,0,32'hDEADBEEF,64'h0,64'h0,0,0, 0,8'h00,32'h0,64'h0,64'h0};
      tbl[4]  = '{1,1,0,2'd3,1,32'h0008,64'h0,64'h8000000000000001,1,2,
                  0,8'hFF,32'h0008,64'h0,64'h8000000000000001};
      tbl[5]  = '{0,1,0,2'd3,0,32'h0010,64'h0,64'h0,0,0, 1,8'h00,32'h0,64'h0,64'h0};
      tbl[6]  = '{0,1,0,2'd1,0,32'h0002,64'h0,64'h87654321,0,1, 0,8'h0C,32'h0,64'h0,64'h8765};
      tbl[7]  = '{0,1,0,2'd1,1,32'h0002,64'h0,64'h87654321,2,0, 0,8'h0C,32'h0,64'h0,64'hFFFF8765};
      tbl[8]  = '{0,0,1,2'd0,0,32'h0005,64'hAB,64'h0,1,0, 0,8'h02,32'h4,64'hABABABAB,64'h0};
      tbl[9]  = '{1,1,0,2'd2,1,32'h0014,64'h0,64'h89ABCDEF01234567,0,3,
                  0,8'hF0,32'h10,64'h0,64'hFFFFFFFF89ABCDEF};
      tbl[10] = '{1,0,1,2'd0,0,32'h0007,64'h5A,64'h0,0,0, 0,8'h80,32'h0,64'h5A5A5A5A5A5A5A5A,64'h0};
      tbl[11] = '{1,1,0,2'd3,0,32'h0004,64'h0,64'h0,0,0, 1,8'h00,32'h0,64'h0,64'h0};
      tbl[12] = '{1,0,1,2'd3,0,32'h0018,64'h0123456789ABCDEF,64'h0,2,0,
                  0,8'hFF,32'h18,64'h0123456789ABCDEF,64'h0};
      tbl[13] = '{0,1,1,2'd2,0,32'h0008,64'hCAFEF00D,64'h0,0,0, 0,8'h0F,32'h8,64'hCAFEF00D,64'h0};
      tbl[14] = '{0,1,0,2'd0,0,32'h1003,64'h0,64'h80FF0000,1,1, 0,8'h08,32'h1000,64'h0,64'h80};

      // Reset state on both instances.
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel64 = s[0];
         #1;
         chk("rst_stall", obs_stall, 0);
         chk("rst_out_valid", obs_ov, 0);
         chk("rst_read_data", obs_rd, 0);
         chk("rst_alu_result_out", obs_aro, 0);
         chk("rst_misaligned", obs_mis, 0);
         chk("rst_dmem_req", obs_req, 0);
         chk("rst_dmem_we", obs_we, 0);
         chk("rst_dmem_be", obs_be, 0);
         chk("rst_dmem_wdata", obs_wd, 0);
         chk("rst_dmem_addr", obs_addr, 0);
      end
      @(negedge clk);
      rst = 1'b0; sel64 = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_out_valid", obs_ov, 0);

      foreach (tbl[i])
         do_op(tbl[i].s64, tbl[i].rd, tbl[i].wr, tbl[i].ty, tbl[i].sx, tbl[i].addr, tbl[i].wd,
               tbl[i].rdat, tbl[i].gd, tbl[i].rdl, tbl[i].e_mis, tbl[i].e_be, tbl[i].e_addr,
               tbl[i].e_wd, tbl[i].e_rd);

      // Reset while waiting for read data: access is dropped, late rvalid ignored.
      txn++;
      @(negedge clk);
      sel64 = 1'b0; in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
      type_control = 2'd2; alu_result = 32'h40;
      @(negedge clk);
      in_valid = 1'b0;
      chk("abort_req", obs_req, 1);
      gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0;
      chk("abort_wait_req", obs_req, 0);
      #1 chk("abort_wait_stall", obs_stall, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1 chk("abort_stall", obs_stall, 0);
      chk("abort_req_low", obs_req, 0);
      rvalid = 1'b1; rdata_in = 64'h1234;
      @(negedge clk);
      rvalid = 1'b0;
      chk("abort_out_valid", obs_ov, 0);
      #1 chk("abort_stall_after", obs_stall, 0);
      @(negedge clk);
      chk("abort_out_valid2", obs_ov, 0);
      chk("abort_read_data", obs_rd, 0);
      $display("txn %0d reset during WAIT, late rvalid", txn);

      // Random ops against the model.
      for (int n = 0; n < 150; n++) begin
         bit          s64 = 1'($urandom);
         int          kind = $urandom_range(0, 5);
         bit          rd = (kind == 1 || kind == 2 || kind == 5);
         bit          wr = (kind == 3 || kind == 4 || kind == 5);
         logic [1:0]  ty = 2'($urandom);
         bit          sx = 1'($urandom);
         logic [31:0] a = $urandom;
         logic [63:0] wd = {$urandom, $urandom};
         logic [63:0] rdat = {$urandom, $urandom};
         int          gd = $urandom_range(0, 3);
         int          rdl = $urandom_range(0, 3);
         bit          mis;
         if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << ty) - 32'd1);
         if (!s64) begin wd[63:32] = '0; rdat[63:32] = '0; end
         mis = (rd | wr) && m_mis(s64, ty, a);
         do_op(s64, rd, wr, ty, sx, a, wd, rdat, gd, rdl, mis, m_be(s64, ty, a),
               a - (a % (s64 ? 8 : 4)), m_wd(s64, ty, wd), m_rd(s64, ty, sx, a, rdat));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
